unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory bus between the pipeline's instruction-fetch port (I) and load/store port (D).
- Grants one requester at a time and holds address/data stable until the memory signals ready.
- Returns read data with a one-cycle ack pulse and drives the stall signals that freeze the F and M stages while a request is pending.
- Sits between the datapath/controller and the memory.

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter_if.sv | 55 +++++
 rtl/unified_mem_arbiter_arb_pick2.sv | 29 ++
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared state and grant-id encodings for the unified memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } arbState_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter_if
//  Brief    : Fetch, load/store, memory and stall signals of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_be;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;

    logic              stall_f;
    logic              stall_m;

    // Arbiter side: serves both requesters and masters the memory bus.
    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack,
        output m_req, m_we, m_addr, m_wdata, m_be,
        output stall_f, stall_m
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        input  stall_f, stall_m
    );

endinterface : unified_mem_arbiter_if
`default_nettype wire

// File: rtl/unified_mem_arbiter_arb_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pick2
//  Brief    : Two-way combinational picker; on contention the port that did
//             not finish last wins, D being preferred otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_pick2
    import mem_arb_pkg::*;
(
    input  wire logic req_i,
    input  wire logic req_d,
    input  wire logic last_grant,
    output logic      gnt_valid,
    output logic      gnt_id
);

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_id    = GNT_I;
        if (req_i && req_d) begin
            gnt_id = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (req_d) begin
            gnt_id = GNT_D;
        end
    end

endmodule : arb_pick2
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Brief    : Shares one single-port memory between instruction fetch and
//             load/store, holding the granted access until m_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    unified_mem_arbiter_if.master  bus
);

    localparam int BW = DW / 8;

    arbState_t        r_state;
    logic             r_lastGrant;
    logic             r_mReq;
    logic             r_mWe;
    logic [AW-1:0]    r_mAddr;
    logic [DW-1:0]    r_mWdata;
    logic [BW-1:0]    r_mBe;
    logic [DW-1:0]    r_iRdata;
    logic [DW-1:0]    r_dRdata;
    logic             r_iAck;
    logic             r_dAck;

    logic             w_eligI;
    logic             w_eligD;
    logic             w_gntValid;
    logic             w_gntId;

    // A port whose ack is up this cycle still shows req; it must not re-win.
    assign w_eligI = bus.i_req & ~r_iAck;
    assign w_eligD = bus.d_req & ~r_dAck;

    arb_pick2 u_pick (
        .req_i      (w_eligI),
        .req_d      (w_eligD),
        .last_grant (r_lastGrant),
        .gnt_valid  (w_gntValid),
        .gnt_id     (w_gntId)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lastGrant <= GNT_I;
            r_mReq      <= 1'b0;
            r_mWe       <= 1'b0;
            r_mAddr     <= '0;
            r_mWdata    <= '0;
            r_mBe       <= '0;
            r_iRdata    <= '0;
            r_dRdata    <= '0;
            r_iAck      <= 1'b0;
            r_dAck      <= 1'b0;
        end else begin
            r_iAck <= 1'b0;
            r_dAck <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gntValid) begin
                        r_mReq <= 1'b1;
                        if (w_gntId == GNT_D) begin
                            r_state  <= DBUS;
                            r_mWe    <= bus.d_we;
                            r_mAddr  <= bus.d_addr;
                            r_mWdata <= bus.d_wdata;
                            r_mBe    <= bus.d_be;
                        end else begin
                            r_state  <= IBUS;
                            r_mWe    <= 1'b0;
                            r_mAddr  <= bus.i_addr;
                            r_mWdata <= '0;
                            r_mBe    <= '1;
                        end
                    end
                end
                IBUS: begin
                    if (bus.m_ready) begin
                        r_iRdata    <= bus.m_rdata;
                        r_iAck      <= 1'b1;
                        r_lastGrant <= GNT_I;
                        r_mReq      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                DBUS: begin
                    if (bus.m_ready) begin
                        if (!r_mWe) begin
                            r_dRdata <= bus.m_rdata;
                        end
                        r_dAck      <= 1'b1;
                        r_lastGrant <= GNT_D;
                        r_mReq      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_mReq  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_req   = r_mReq;
    assign bus.m_we    = r_mWe;
    assign bus.m_addr  = r_mAddr;
    assign bus.m_wdata = r_mWdata;
    assign bus.m_be    = r_mBe;
    assign bus.i_rdata = r_iRdata;
    assign bus.d_rdata = r_dRdata;
    assign bus.i_ack   = r_iAck;
    assign bus.d_ack   = r_dAck;
    assign bus.stall_f = w_eligI;
    assign bus.stall_m = w_eligD;

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_arbiter
//  Brief    : Directed self-checking bench for the unified memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    unified_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
        bus.m_rdata = '0;
        bus.m_ready = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_m_req"},   64'(bus.m_req),   64'd0);
        checkVal({tag, "_m_we"},    64'(bus.m_we),    64'd0);
        checkVal({tag, "_m_addr"},  64'(bus.m_addr),  64'd0);
        checkVal({tag, "_m_wdata"}, 64'(bus.m_wdata), 64'd0);
        checkVal({tag, "_m_be"},    64'(bus.m_be),    64'd0);
        checkVal({tag, "_i_ack"},   64'(bus.i_ack),   64'd0);
        checkVal({tag, "_d_ack"},   64'(bus.d_ack),   64'd0);
        checkVal({tag, "_i_rdata"}, 64'(bus.i_rdata), 64'd0);
        checkVal({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
    endtask

    initial begin
        logic [31:0] expAddr [4];
        logic        expIsD  [4];
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clearInputs();

        // Reset state
        tick();
        checkAllZero("rst");
        doReset();
        checkAllZero("rst_rel");

        // Fetch with zero-wait memory
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h100;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h00500093;
        #1;
        checkVal("f_c0_stall_f", 64'(bus.stall_f), 64'd1);
        checkVal("f_c0_m_req",   64'(bus.m_req),   64'd0);
        tick();
        checkVal("f_c1_m_req",   64'(bus.m_req),   64'd1);
        checkVal("f_c1_m_addr",  64'(bus.m_addr),  64'h100);
        checkVal("f_c1_m_be",    64'(bus.m_be),    64'hF);
        checkVal("f_c1_m_we",    64'(bus.m_we),    64'd0);
        checkVal("f_c1_stall_f", 64'(bus.stall_f), 64'd1);
        checkVal("f_c1_i_ack",   64'(bus.i_ack),   64'd0);
        tick();
        checkVal("f_c2_i_ack",   64'(bus.i_ack),   64'd1);
        checkVal("f_c2_i_rdata", 64'(bus.i_rdata), 64'h00500093);
        checkVal("f_c2_stall_f", 64'(bus.stall_f), 64'd0);
        checkVal("f_c2_m_req",   64'(bus.m_req),   64'd0);
        bus.i_req = 1'b0;
        tick();
        checkVal("f_c3_i_ack",   64'(bus.i_ack),   64'd0);
        checkVal("f_c3_i_rdata", 64'(bus.i_rdata), 64'h00500093);

        // Simultaneous requests straight out of reset: D wins first
        clearInputs();
        doReset();
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h104;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h2000;
        bus.d_be    = 4'hF;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h11112222;
        tick();
        checkVal("b_c1_m_addr",  64'(bus.m_addr),  64'h2000);
        checkVal("b_c1_m_we",    64'(bus.m_we),    64'd0);
        tick();
        checkVal("b_c2_d_ack",   64'(bus.d_ack),   64'd1);
        checkVal("b_c2_i_ack",   64'(bus.i_ack),   64'd0);
        checkVal("b_c2_d_rdata", 64'(bus.d_rdata), 64'h11112222);
        checkVal("b_c2_m_req",   64'(bus.m_req),   64'd0);
        bus.d_req   = 1'b0;
        bus.m_rdata = 32'h33334444;
        tick();
        checkVal("b_c3_m_req",   64'(bus.m_req),   64'd1);
        checkVal("b_c3_m_addr",  64'(bus.m_addr),  64'h104);
        checkVal("b_c3_m_be",    64'(bus.m_be),    64'hF);
        tick();
        checkVal("b_c4_i_ack",   64'(bus.i_ack),   64'd1);
        checkVal("b_c4_i_rdata", 64'(bus.i_rdata), 64'h33334444);
        checkVal("b_c4_d_rdata", 64'(bus.d_rdata), 64'h11112222);
        bus.i_req = 1'b0;
        tick();

        // Both held continuously; last finisher was I, so D, I, D, I
        expAddr[0] = 32'h3000; expIsD[0] = 1'b1;
        expAddr[1] = 32'h200;  expIsD[1] = 1'b0;
        expAddr[2] = 32'h3000; expIsD[2] = 1'b1;
        expAddr[3] = 32'h200;  expIsD[3] = 1'b0;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h3000;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0A0B0C0D;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkVal($sformatf("alt%0d_m_addr", k), 64'(bus.m_addr), 64'(expAddr[k]));
            tick();
            checkVal($sformatf("alt%0d_d_ack", k), 64'(bus.d_ack), 64'(expIsD[k]));
            checkVal($sformatf("alt%0d_i_ack", k), 64'(bus.i_ack), 64'(!expIsD[k]));
        end
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();

        // Store with three wait states
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2004;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_be    = 4'h3;
        bus.m_rdata = 32'hFFFFFFFF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) bus.m_ready = 1'b1;
            #1;
            checkVal($sformatf("st_c%0d_m_req", c),   64'(bus.m_req),   64'd1);
            checkVal($sformatf("st_c%0d_m_we", c),    64'(bus.m_we),    64'd1);
            checkVal($sformatf("st_c%0d_m_addr", c),  64'(bus.m_addr),  64'h2004);
            checkVal($sformatf("st_c%0d_m_wdata", c), 64'(bus.m_wdata), 64'hDEADBEEF);
            checkVal($sformatf("st_c%0d_m_be", c),    64'(bus.m_be),    64'h3);
            checkVal($sformatf("st_c%0d_d_ack", c),   64'(bus.d_ack),   64'd0);
            checkVal($sformatf("st_c%0d_stall_m", c), 64'(bus.stall_m), 64'd1);
        end
        tick();
        checkVal("st_ack",     64'(bus.d_ack),   64'd1);
        checkVal("st_stall_m", 64'(bus.stall_m), 64'd0);
        checkVal("st_d_rdata", 64'(bus.d_rdata), 64'h0A0B0C0D);
        checkVal("st_m_req",   64'(bus.m_req),   64'd0);
        clearInputs();
        tick();
        checkVal("st_ack_pulse", 64'(bus.d_ack), 64'd0);

        // m_ready while idle is ignored
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        checkVal("idle_rdy_m_req", 64'(bus.m_req), 64'd0);
        checkVal("idle_rdy_i_ack", 64'(bus.i_ack), 64'd0);
        checkVal("idle_rdy_d_ack", 64'(bus.d_ack), 64'd0);
        tick();
        checkVal("idle_rdy2_ack", 64'({bus.i_ack, bus.d_ack, bus.m_req}), 64'd0);

        // Address change after grant ignored; early req drop still acks
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        bus.m_rdata = 32'hCAFEF00D;
        tick();
        checkVal("chg_c1_m_addr", 64'(bus.m_addr), 64'h300);
        bus.i_addr = 32'h444;
        tick();
        checkVal("chg_c2_m_addr", 64'(bus.m_addr), 64'h300);
        checkVal("chg_c2_i_ack",  64'(bus.i_ack),  64'd0);
        bus.i_req   = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        checkVal("chg_ack",     64'(bus.i_ack),   64'd1);
        checkVal("chg_i_rdata", 64'(bus.i_rdata), 64'hCAFEF00D);
        bus.m_ready = 1'b0;
        tick();

        // Reset mid-DBUS abandons the access
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h5000;
        bus.d_be   = 4'hF;
        tick();
        checkVal("mr_m_req_before", 64'(bus.m_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkVal("mr_m_req_async", 64'(bus.m_req), 64'd0);
        checkVal("mr_d_ack",       64'(bus.d_ack), 64'd0);
        clearInputs();
        bus.m_ready = 1'b1;
        tick();
        checkVal("mr_d_ack_hold", 64'(bus.d_ack), 64'd0);
        reset = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        checkAllZero("mr_rel");
        tick();
        checkAllZero("mr_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
`default_nettype wire
